// File: rtl/arb_rr_ctrl.sv
// Round-robin arbiter steering four input FIFOs onto four output FIFOs.
// Grants are combinational in ACTIVE; per-destination push counters saturate.

module arb_rr_cnt #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)                 cnt <= '0;
        else if (clr)                 cnt <= '0;
        else if (inc && (cnt != '1))  cnt <= cnt + 1'b1;
    end
endmodule

module arb_rr_ctrl #(
    parameter int FIFO_UNITS = 4,
    parameter int WORD_SIZE  = 10,
    parameter int PTR_L      = 3,
    parameter int CNT_W      = 5
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic                    init,
    input  logic [FIFO_UNITS-1:0]   fifo_empty,
    input  logic [2*FIFO_UNITS-1:0] head_dest,
    input  logic [FIFO_UNITS-1:0]   fifo_almost_full,
    output logic [FIFO_UNITS-1:0]   arb_pop,
    output logic [FIFO_UNITS-1:0]   arb_push,
    output logic [CNT_W-1:0]        cnt0,
    output logic [CNT_W-1:0]        cnt1,
    output logic [CNT_W-1:0]        cnt2,
    output logic [CNT_W-1:0]        cnt3,
    output logic                    idle
);
    // The select and destination fields are 2 bits wide, so only 4 units work.
    if (FIFO_UNITS != 4 || WORD_SIZE < 1 || PTR_L < 1) begin : g_param_chk
        $error("arb_rr_ctrl supports exactly 4 FIFO units");
    end

    typedef enum logic [1:0] {S_RESET, S_INIT, S_IDLE, S_ACTIVE} state_t;

    state_t                              state;
    logic [1:0]                          rr_ptr;
    logic [1:0]                          sel;
    logic [FIFO_UNITS-1:0][1:0]          dest;
    logic [FIFO_UNITS-1:0]               elig;
    logic                                any_elig;
    logic                                grant;
    logic                                cnt_clr;
    logic [FIFO_UNITS-1:0][CNT_W-1:0]    cnt;

    assign dest = head_dest;

    for (genvar i = 0; i < FIFO_UNITS; i++) begin : g_elig
        assign elig[i] = ~fifo_empty[i] & ~fifo_almost_full[dest[i]];
    end

    assign any_elig = |elig;
    assign grant    = (state == S_ACTIVE) && !init && any_elig;

    // Scan from the farthest offset down so the nearest eligible input wins.
    always_comb begin
        sel = rr_ptr;
        for (int k = FIFO_UNITS - 1; k >= 0; k--) begin
            if (elig[rr_ptr + 2'(k)]) sel = rr_ptr + 2'(k);
        end
    end

    always_comb begin
        arb_pop  = '0;
        arb_push = '0;
        if (grant) begin
            arb_pop[sel]        = 1'b1;
            arb_push[dest[sel]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state  <= S_RESET;
            rr_ptr <= '0;
        end else begin
            case (state)
                S_RESET:  state <= S_INIT;
                S_INIT:   if (!init) state <= S_IDLE;
                S_IDLE:   if (init) state <= S_INIT;
                          else if (any_elig) state <= S_ACTIVE;
                S_ACTIVE: if (init) state <= S_INIT;
                          else if (!any_elig) state <= S_IDLE;
                default:  state <= S_RESET;
            endcase
            if (grant) rr_ptr <= sel + 2'd1;
        end
    end

    assign idle    = (state == S_IDLE);
    assign cnt_clr = init || (state == S_INIT) || (state == S_RESET);

    for (genvar d = 0; d < FIFO_UNITS; d++) begin : g_cnt
        arb_rr_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk     (clk),
            .reset_L (reset_L),
            .clr     (cnt_clr),
            .inc     (arb_push[d]),
            .cnt     (cnt[d])
        );
    end

    assign cnt0 = cnt[0];
    assign cnt1 = cnt[1];
    assign cnt2 = cnt[2];
    assign cnt3 = cnt[3];
endmodule

// File: tb/tb_arb_rr_ctrl.sv
// Randomized bench for arb_rr_ctrl against a behavioural round-robin model.

module tb_arb_rr_ctrl;
    localparam int CNT_W   = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int M_RESET = 0, M_INIT = 1, M_IDLE = 2, M_ACTIVE = 3;

    logic             clk = 1'b0;
    logic             reset_L;
    logic             init;
    logic [3:0]       fifo_empty;
    logic [7:0]       head_dest;
    logic [3:0]       fifo_almost_full;
    logic [3:0]       arb_pop;
    logic [3:0]       arb_push;
    logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;
    logic             idle;

    int n_cmp = 0;
    int n_bad = 0;

    int m_state;
    int m_rr;
    int m_cnt[4];

    always #5 clk = ~clk;

    arb_rr_ctrl #(.FIFO_UNITS(4), .WORD_SIZE(10), .PTR_L(3), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset_L          (reset_L),
        .init             (init),
        .fifo_empty       (fifo_empty),
        .head_dest        (head_dest),
        .fifo_almost_full (fifo_almost_full),
        .arb_pop          (arb_pop),
        .arb_push         (arb_push),
        .cnt0             (cnt0),
        .cnt1             (cnt1),
        .cnt2             (cnt2),
        .cnt3             (cnt3),
        .idle             (idle)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_dest(input int i);
        return int'(head_dest[2*i +: 2]);
    endfunction

    function automatic bit m_elig(input int i);
        return !fifo_empty[i] && !fifo_almost_full[m_dest(i)];
    endfunction

    // First eligible input going round from the pointer, or -1 if none.
    function automatic int m_sel();
        for (int k = 0; k < 4; k++)
            if (m_elig((m_rr + k) % 4)) return (m_rr + k) % 4;
        return -1;
    endfunction

    function automatic bit m_grant();
        return reset_L && m_state == M_ACTIVE && !init && m_sel() >= 0;
    endfunction

    task automatic m_reset();
        m_state = M_RESET;
        m_rr    = 0;
        for (int d = 0; d < 4; d++) m_cnt[d] = 0;
    endtask

    task automatic m_edge();
        int s;
        bit g;
        int old;
        if (!reset_L) begin
            m_reset();
            return;
        end
        s   = m_sel();
        g   = m_grant();
        old = m_state;
        case (old)
            M_RESET:  m_state = M_INIT;
            M_INIT:   m_state = init ? M_INIT : M_IDLE;
            M_IDLE:   m_state = init ? M_INIT : (s >= 0 ? M_ACTIVE : M_IDLE);
            default:  m_state = init ? M_INIT : (s >= 0 ? M_ACTIVE : M_IDLE);
        endcase
        if (g) begin
            m_rr = (s + 1) % 4;
            if (m_cnt[m_dest(s)] < CNT_MAX) m_cnt[m_dest(s)]++;
        end
        if (init || old == M_INIT || old == M_RESET)
            for (int d = 0; d < 4; d++) m_cnt[d] = 0;
    endtask

    task automatic check_all(input string tag);
        int exp_pop;
        int exp_push;
        exp_pop  = 0;
        exp_push = 0;
        if (m_grant()) begin
            exp_pop  = 1 << m_sel();
            exp_push = 1 << m_dest(m_sel());
        end
        chk({tag, "_pop"},  int'(arb_pop),  exp_pop);
        chk({tag, "_push"}, int'(arb_push), exp_push);
        chk({tag, "_idle"}, int'(idle),     int'(m_state == M_IDLE));
        chk({tag, "_cnt0"}, int'(cnt0),     m_cnt[0]);
        chk({tag, "_cnt1"}, int'(cnt1),     m_cnt[1]);
        chk({tag, "_cnt2"}, int'(cnt2),     m_cnt[2]);
        chk({tag, "_cnt3"}, int'(cnt3),     m_cnt[3]);
    endtask

    // Check mid-low phase, advance model on the edge, return just after it.
    task automatic step(input string tag);
        @(negedge clk);
        check_all(tag);
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic init_pulse();
        init = 1'b1;
        step("initp");
        init = 1'b0;
        step("initr");
    endtask

    initial begin
        reset_L          = 1'b0;
        init             = 1'b0;
        fifo_empty       = 4'hF;
        head_dest        = 8'h00;
        fifo_almost_full = 4'h0;
        m_reset();

        step("rst");
        step("rst");
        reset_L = 1'b1;
        init    = 1'b1;
        step("seq_reset");
        step("seq_init1");
        init = 1'b0;
        step("seq_init2");
        chk("idle_after_init", int'(idle), 1);

        // Single input 2 heading to output 3.
        fifo_empty = 4'b1011;
        head_dest  = 8'b00_11_00_00;
        for (int i = 0; i < 4; i++) step("single");
        chk("cnt3_single", int'(cnt3), 3);

        // Everyone targets output 0: strict rotation.
        init_pulse();
        fifo_empty = 4'b0000;
        head_dest  = 8'h00;
        for (int i = 0; i < 5; i++) step("rr_all");
        chk("cnt0_four", int'(cnt0), 4);

        // Input 0 blocked by almost-full on output 2, input 1 keeps flowing.
        init_pulse();
        fifo_empty       = 4'b1100;
        head_dest        = 8'b00_00_01_10;
        fifo_almost_full = 4'b0100;
        for (int i = 0; i < 4; i++) step("af_block");
        chk("cnt2_blocked", int'(cnt2), 0);
        fifo_almost_full = 4'b0000;
        for (int i = 0; i < 3; i++) step("af_release");

        // Saturation on output 1.
        init_pulse();
        fifo_empty = 4'b0000;
        head_dest  = 8'b01_01_01_01;
        for (int i = 0; i < 42; i++) step("sat");
        chk("cnt1_sat", int'(cnt1), CNT_MAX);

        // Randomized traffic with occasional re-init.
        for (int i = 0; i < 400; i++) begin
            fifo_empty       = 4'($urandom);
            head_dest        = 8'($urandom);
            fifo_almost_full = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            init             = ($urandom_range(0, 24) == 0);
            step("rand");
        end
        init = 1'b0;

        // Asynchronous reset while a grant is on the wires.
        init_pulse();
        fifo_empty       = 4'b0000;
        head_dest        = 8'h00;
        fifo_almost_full = 4'h0;
        step("pre_rst");
        step("pre_rst");
        #1;
        chk("mid_pop_live", int'(arb_pop != 0), 1);
        reset_L = 1'b0;
        m_reset();
        #1;
        chk("mid_rst_pop",  int'(arb_pop),  0);
        chk("mid_rst_push", int'(arb_push), 0);
        chk("mid_rst_cnt0", int'(cnt0),     0);
        step("in_rst");
        reset_L = 1'b1;
        for (int i = 0; i < 6; i++) step("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
